// File: rtl/v_stage_param_collector.sv
// Read-side master for one Haar stage database: gathers per-classifier records and stage thresholds.
// Optional marker checking is compiled in with `define PARAM_MARKER_CHECK_EN.
module v_stage_param_collector #(
  parameter int ADDR_WIDTH               = 12,
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_CLASSIFIERS_STAGE    = 32,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_STAGE_THRESHOLD      = 3
) (
  input  logic                                              clk_fpga,
  input  logic                                              reset_fpga,
  input  logic                                              i_start,
  output logic                                              o_rden,
  input  logic [DATA_WIDTH_12-1:0]                          i_data,
  input  logic                                              i_end_single_classifier,
  input  logic                                              i_end_database,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_12-1:0] o_param,
  output logic [ADDR_WIDTH-1:0]                             o_classifier_index,
  output logic                                              o_valid,
  input  logic                                              i_ready,
  output logic [NUM_STAGE_THRESHOLD*DATA_WIDTH_12-1:0]      o_stage_threshold,
  output logic                                              o_done,
  output logic                                              o_busy,
  output logic                                              o_err
);
  localparam int NP   = NUM_PARAM_PER_CLASSIFIER;
  localparam int NT   = NUM_STAGE_THRESHOLD;
  localparam int DW   = DATA_WIDTH_12;
  localparam int WMAX = (NP > NT) ? NP : NT;
  localparam int WCW  = $clog2(WMAX);

  localparam logic [WCW-1:0]        W_LAST_P = WCW'(NP - 1);
  localparam logic [WCW-1:0]        W_LAST_T = WCW'(NT - 1);
  localparam logic [ADDR_WIDTH-1:0] C_LAST   = ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1);

  typedef enum logic [2:0] {IDLE, REQ, CAPT, EMIT, TREQ, TCAPT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [WCW-1:0]           word_cnt;
  logic [ADDR_WIDTH-1:0]    cls_cnt;
  logic [NP-1:0][DW-1:0]    param_q;
  logic [NT-1:0][DW-1:0]    thr_q;
  logic                     last_p, last_t, last_c;

  assign last_p = (word_cnt == W_LAST_P);
  assign last_t = (word_cnt == W_LAST_T);
  assign last_c = (cls_cnt == C_LAST);

  assign o_param            = param_q;
  assign o_stage_threshold  = thr_q;
  assign o_classifier_index = cls_cnt;

  always_ff @(posedge clk_fpga or posedge reset_fpga)
    if (reset_fpga) state_q <= IDLE;
    else            state_q <= state_d;

  // Backpressure in EMIT stalls the read stream: no request is issued until the record is taken.
  always_comb begin
    state_d = state_q;
    o_rden  = 1'b0;
    o_valid = 1'b0;
    o_done  = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      IDLE:  if (i_start) state_d = REQ;
      REQ:   begin o_busy = 1'b1; o_rden = 1'b1; state_d = CAPT; end
      CAPT:  begin o_busy = 1'b1; state_d = last_p ? EMIT : REQ; end
      EMIT:  begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_d = last_c ? TREQ : REQ;
      end
      TREQ:  begin o_busy = 1'b1; o_rden = 1'b1; state_d = TCAPT; end
      TCAPT: begin o_busy = 1'b1; state_d = last_t ? DONE : TREQ; end
      DONE:  begin o_done = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or posedge reset_fpga)
    if (reset_fpga) begin
      word_cnt <= '0;
      cls_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE:  if (i_start) begin word_cnt <= '0; cls_cnt <= '0; end
        CAPT:  word_cnt <= last_p ? '0 : word_cnt + 1'b1;
        EMIT:  if (i_ready && !last_c) cls_cnt <= cls_cnt + 1'b1;
        TCAPT: word_cnt <= last_t ? '0 : word_cnt + 1'b1;
        default: ;
      endcase
    end

  always_ff @(posedge clk_fpga or posedge reset_fpga)
    if (reset_fpga) begin
      param_q <= '0;
      thr_q   <= '0;
    end else begin
      for (int k = 0; k < NP; k++)
        if (state_q == CAPT && word_cnt == WCW'(k)) param_q[k] <= i_data;
      for (int k = 0; k < NT; k++)
        if (state_q == TCAPT && word_cnt == WCW'(k)) thr_q[k] <= i_data;
    end

`ifdef PARAM_MARKER_CHECK_EN
  // Markers ride with i_data, so they are judged in the capture cycles only.
  logic mark_bad;
  always_comb begin
    mark_bad = 1'b0;
    if (state_q == CAPT)
      mark_bad = (i_end_single_classifier != last_p) || i_end_database;
    else if (state_q == TCAPT)
      mark_bad = (i_end_database != last_t);
  end

  always_ff @(posedge clk_fpga or posedge reset_fpga)
    if (reset_fpga)                      o_err <= 1'b0;
    else if (state_q == IDLE && i_start) o_err <= 1'b0;
    else if (mark_bad)                   o_err <= 1'b1;
`else
  logic unused_markers;
  assign unused_markers = i_end_single_classifier ^ i_end_database;
  assign o_err          = 1'b0;
`endif

endmodule
